// File: rtl/mult_err_stats_pkg.sv
// Shared types and default widths for the multiplier error-statistics block.
package mult_err_stats_pkg;

  localparam int DEF_M  = 16;
  localparam int DEF_CW = 16;
  localparam int DEF_SW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_err_absdiff.sv
// Exact unsigned absolute difference |a - b|, purely combinational.
module mult_err_absdiff
  import mult_err_stats_pkg::*;
#(
  parameter int M = DEF_M
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] d
);

  // Subtract the smaller operand from the larger so the result never wraps.
  always_comb begin
    d = (a >= b) ? (a - b) : (b - a);
  end

endmodule

// File: rtl/mult_err_stats.sv
// Accumulates error statistics between an exact and an approximate
// multiplier product over a run of num_samples accepted samples.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | after reset, waiting for start
//   ST_RUN  | accepting samples until num_samples have been applied
//   ST_DONE | statistics final and held until the next start
module mult_err_stats
  import mult_err_stats_pkg::*;
#(
  parameter int M  = DEF_M,
  parameter int CW = DEF_CW,
  parameter int SW = DEF_SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_samples,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  p_ref,
  input  logic [M-1:0]  p_dut,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] sample_count,
  output logic [CW-1:0] err_count,
  output logic [M-1:0]  max_ed,
  output logic [SW-1:0] sum_ed,
  output logic          sum_sat
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [SW-1:0] SUM_MAX = '1;

  state_e        state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [M-1:0]  ed_q, ed_d;
  logic          ed_vld_q, ed_vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] err_q, err_d;
  logic [M-1:0]  max_q, max_d;
  logic [SW-1:0] sum_q, sum_d;
  logic          sat_q, sat_d;

  logic [M-1:0]  ed_w;
  logic          accept;
  logic [SW:0]   sum_ext;
  logic [CW-1:0] cnt_inc;

  mult_err_absdiff #(.M(M)) u_absdiff (
    .a (p_ref),
    .b (p_dut),
    .d (ed_w)
  );

  // Handshake and outputs come straight from registered state.
  always_comb begin
    in_ready     = (state_q == ST_RUN) && (acc_q < n_q);
    accept       = in_valid && in_ready;
    busy         = (state_q == ST_RUN);
    done         = (state_q == ST_DONE);
    sample_count = cnt_q;
    err_count    = err_q;
    max_ed       = max_q;
    sum_ed       = sum_q;
    sum_sat      = sat_q;
  end

  // Next-state: apply the registered ED, capture a new ED, or start a run.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    acc_d    = acc_q;
    ed_d     = ed_q;
    ed_vld_d = 1'b0;
    cnt_d    = cnt_q;
    err_d    = err_q;
    max_d    = max_q;
    sum_d    = sum_q;
    sat_d    = sat_q;
    // One extra bit catches the carry that signals saturation.
    sum_ext  = {1'b0, sum_q} + (SW+1)'(ed_q);
    cnt_inc  = cnt_q + CNT_ONE;

    // Statistics stage: only ever valid in RUN, one edge after acceptance.
    if (ed_vld_q) begin
      cnt_d = cnt_inc;
      if (ed_q != '0) begin
        err_d = err_q + CNT_ONE;
      end
      if (ed_q > max_q) begin
        max_d = ed_q;
      end
      if (sum_ext[SW]) begin
        sum_d = SUM_MAX;
        sat_d = 1'b1;
      end else begin
        sum_d = sum_ext[SW-1:0];
      end
      if (cnt_inc == n_q) begin
        state_d = ST_DONE;
      end
    end

    // Acceptance stage: register the ED of the handshaken sample.
    if (accept) begin
      ed_d     = ed_w;
      ed_vld_d = 1'b1;
      acc_d    = acc_q + CNT_ONE;
    end

    // A start is only honoured outside RUN; a zero-length run ends at once.
    if (start && (state_q != ST_RUN)) begin
      n_d      = num_samples;
      acc_d    = '0;
      ed_d     = '0;
      ed_vld_d = 1'b0;
      cnt_d    = '0;
      err_d    = '0;
      max_d    = '0;
      sum_d    = '0;
      sat_d    = 1'b0;
      state_d  = (num_samples == '0) ? ST_DONE : ST_RUN;
    end
  end

  // State register with asynchronous clear of every flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      acc_q    <= '0;
      ed_q     <= '0;
      ed_vld_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= '0;
      max_q    <= '0;
      sum_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      ed_q     <= ed_d;
      ed_vld_q <= ed_vld_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      max_q    <= max_d;
      sum_q    <= sum_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_mult_err_stats.sv
// Directed bench for mult_err_stats with a cycle-level behavioural model.
module tb_mult_err_stats;

  localparam int M  = 16;
  localparam int CW = 16;
  localparam int SW = 18;
  localparam longint SUM_MAX = (longint'(1) << SW) - 1;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [M-1:0]  p_ref = '0;
  logic [M-1:0]  p_dut = '0;
  logic          busy;
  logic          done;
  logic [CW-1:0] sample_count;
  logic [CW-1:0] err_count;
  logic [M-1:0]  max_ed;
  logic [SW-1:0] sum_ed;
  logic          sum_sat;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mult_err_stats #(.M(M), .CW(CW), .SW(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .p_ref        (p_ref),
    .p_dut        (p_dut),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .err_count    (err_count),
    .max_ed       (max_ed),
    .sum_ed       (sum_ed),
    .sum_sat      (sum_sat)
  );

  // Behavioural model: run phase, accepted count and plain-integer statistics.
  int     mph = P_IDLE;
  longint m_n = 0, m_acc = 0, m_cnt = 0, m_err = 0, m_max = 0, m_sum = 0;
  bit     m_sat = 0, m_pend = 0;
  longint m_ped = 0;

  always @(posedge clk or posedge rst) begin
    int     old_ph;
    bit     take;
    longint a, b, ed;
    if (rst) begin
      mph = P_IDLE; m_n = 0; m_acc = 0; m_cnt = 0; m_err = 0; m_max = 0;
      m_sum = 0; m_sat = 0; m_pend = 0; m_ped = 0;
    end else begin
      old_ph = mph;
      take = (old_ph == P_RUN) && (m_acc < m_n) && in_valid;
      a = longint'(p_ref);
      b = longint'(p_dut);
      ed = (a > b) ? a - b : b - a;
      if (m_pend) begin
        m_cnt = m_cnt + 1;
        if (m_ped != 0) m_err = m_err + 1;
        if (m_ped > m_max) m_max = m_ped;
        m_sum = m_sum + m_ped;
        if (m_sum > SUM_MAX) begin
          m_sum = SUM_MAX;
          m_sat = 1;
        end
        if (m_cnt == m_n) mph = P_DONE;
      end
      m_pend = take;
      if (take) begin
        m_ped = ed;
        m_acc = m_acc + 1;
      end
      if (start && old_ph != P_RUN) begin
        m_n = longint'(num_samples);
        m_acc = 0; m_cnt = 0; m_err = 0; m_max = 0; m_sum = 0; m_sat = 0;
        m_pend = 0;
        mph = (m_n == 0) ? P_DONE : P_RUN;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'((mph == P_RUN) && (m_acc < m_n)));
      chk("busy", 64'(busy), 64'(mph == P_RUN));
      chk("done", 64'(done), 64'(mph == P_DONE));
      chk("sample_count", 64'(sample_count), m_cnt);
      chk("err_count", 64'(err_count), m_err);
      chk("max_ed", 64'(max_ed), m_max);
      chk("sum_ed", 64'(sum_ed), m_sum);
      chk("sum_sat", 64'(sum_sat), 64'(m_sat));
    end
  end

  task automatic timeout_fail(input string what);
    checks++;
    errors++;
    $display("FAIL %s: wait expired, condition never reached at %0t", what, $time);
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    num_samples = CW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for in_ready and presents a sample; leaves in_valid high.
  task automatic present(input int r, input int d);
    int k = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (in_ready !== 1'b1) timeout_fail("present");
    p_ref = M'(r);
    p_dut = M'(d);
    in_valid = 1'b1;
  endtask

  task automatic send(input int r, input int d);
    present(r, d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) timeout_fail("wait_done");
  endtask

  task automatic wait_cnt(input int v);
    int k = 0;
    while (sample_count !== CW'(v) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (sample_count !== CW'(v)) timeout_fail("wait_cnt");
  endtask

  initial begin
    #2 rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_count", 64'(sample_count), 64'd0);

    // Four error-free samples.
    do_start(4);
    for (int i = 0; i < 4; i++) send(1234, 1234);
    wait_done();
    chk("zero_err_count", 64'(sample_count), 64'd4);
    chk("zero_err_errs", 64'(err_count), 64'd0);
    chk("zero_err_max", 64'(max_ed), 64'd0);
    chk("zero_err_sum", 64'(sum_ed), 64'd0);
    chk("zero_err_sat", 64'(sum_sat), 64'd0);

    // Errors in both directions.
    do_start(2);
    send(100, 90);
    send(5, 20);
    wait_done();
    chk("mixed_errs", 64'(err_count), 64'd2);
    chk("mixed_max", 64'(max_ed), 64'd15);
    chk("mixed_sum", 64'(sum_ed), 64'd25);

    // Saturation of an 18-bit sum.
    do_start(5);
    for (int i = 0; i < 4; i++) send(65535, 0);
    wait_cnt(4);
    chk("sat4_sum", 64'(sum_ed), 64'd262140);
    chk("sat4_flag", 64'(sum_sat), 64'd0);
    send(65535, 0);
    wait_done();
    chk("sat5_sum", 64'(sum_ed), 64'd262143);
    chk("sat5_flag", 64'(sum_sat), 64'd1);
    chk("sat5_max", 64'(max_ed), 64'd65535);

    // Zero-length run with valid data offered.
    do_start(0);
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_sum", 64'(sum_ed), 64'd0);
    chk("empty_sat", 64'(sum_sat), 64'd0);
    p_ref = M'(9); p_dut = M'(1); in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("empty_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    chk("empty_count", 64'(sample_count), 64'd0);

    // Gaps, a start mid-run, and valid beyond the last sample.
    do_start(3);
    send(10, 10);
    repeat (3) @(negedge clk);
    send(50, 40);
    start = 1'b1;
    num_samples = CW'(9);
    @(negedge clk);
    start = 1'b0;
    chk("midrun_busy", 64'(busy), 64'd1);
    present(3, 9);
    @(negedge clk);
    p_ref = M'(200); p_dut = M'(1);
    @(negedge clk);
    p_ref = M'(77); p_dut = M'(0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("gap_count", 64'(sample_count), 64'd3);
    chk("gap_errs", 64'(err_count), 64'd2);
    chk("gap_max", 64'(max_ed), 64'd10);
    chk("gap_sum", 64'(sum_ed), 64'd16);
    chk("gap_done_hold", 64'(done), 64'd1);

    // Reset in the middle of a run, then a fresh one-sample run.
    do_start(4);
    send(9, 2);
    send(1, 8);
    wait_cnt(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_count", 64'(sample_count), 64'd0);
    chk("rst_sum", 64'(sum_ed), 64'd0);
    chk("rst_max", 64'(max_ed), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 64'(busy | done), 64'd0);
    do_start(1);
    send(7, 3);
    wait_done();
    chk("after_rst_sum", 64'(sum_ed), 64'd4);
    chk("after_rst_max", 64'(max_ed), 64'd4);
    chk("after_rst_errs", 64'(err_count), 64'd1);
    chk("after_rst_count", 64'(sample_count), 64'd1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
